// File: rtl/updown_counter_n_if.sv
// Control/status bundle for updown_counter_n.
// The master drives the controls; the counter (slave) drives count/tc/ovf.
interface updown_counter_n_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] limit;
   logic             sat_mode;
   logic             clr_ovf;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up, load, load_val, limit, sat_mode, clr_ovf,
      input  count, tc, ovf
   );

   modport slave (
      input  en, up, load, load_val, limit, sat_mode, clr_ovf,
      output count, tc, ovf
   );
endinterface

// File: rtl/updown_counter_n.sv
// Prescaled up/down counter over 0..limit with wrap or saturate at the boundary,
// a one-cycle terminal-count pulse and a sticky boundary flag.
module updown_counter_n #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 1
) (
   input logic              clk,
   input logic              rst,
   updown_counter_n_if.slave bus
);
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] step_val;
   logic             step;
   logic             boundary;
   logic             event_hit;
   logic             tc_q, ovf_q, ovf_d;

   // Load wins over stepping; a step only fires on the last prescaler slot.
   always_comb begin
      step    = bus.en && !bus.load && (presc_q == PS_LAST);
      presc_d = presc_q;
      if (bus.load) begin
         presc_d = '0;
      end else if (bus.en) begin
         presc_d = step ? '0 : presc_q + PW'(1);
      end
   end

   // Next value for a step, and whether that step hits the boundary.
   always_comb begin
      step_val = count_q;
      boundary = 1'b0;
      if (bus.up) begin
         if (count_q < bus.limit) begin
            step_val = count_q + WIDTH'(1);
         end else begin
            boundary = 1'b1;
            step_val = bus.sat_mode ? bus.limit : '0;
         end
      end else begin
         if (count_q == '0) begin
            boundary = 1'b1;
            step_val = bus.sat_mode ? '0 : bus.limit;
         end else if (bus.sat_mode && (count_q > bus.limit)) begin
            step_val = bus.limit;
         end else begin
            step_val = count_q - WIDTH'(1);
         end
      end
   end

   always_comb begin
      event_hit = step && boundary;
      if (bus.load) begin
         count_d = bus.load_val;
      end else if (step) begin
         count_d = step_val;
      end else begin
         count_d = count_q;
      end
      // A boundary event on the same edge keeps ovf set despite clr_ovf.
      if (event_hit) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         presc_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         tc_q    <= event_hit;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;
endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal 2..32).
REQ-002 Parameter: PRESCALE, default 1, enabled cycles per count step (legal 1..65535).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: en  input  1  count enable; prescaler advances only while high.
REQ-006 Port: up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_val  input  WIDTH  value written to count on load.
REQ-009 Port: limit  input  WIDTH  terminal value; count range is 0..limit.
REQ-010 Port: sat_mode  input  1  1 = saturate at boundary, 0 = wrap.
REQ-011 Port: clr_ovf  input  1  clears sticky ovf flag.
REQ-012 Port: count  output  WIDTH  registered counter value.
REQ-013 Port: tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-014 Port: ovf  output  1  sticky boundary-event flag.

Function
REQ-015 Priority per edge SHALL be: rst > load > step; clr_ovf is independent of load/step priority, but rst overrides it.
REQ-016 Prescaler SHALL be an internal counter 0..PRESCALE-1, incremented on each edge with en=1 and no load; a step SHALL occur on the edge where en=1 and prescaler = PRESCALE-1, and the prescaler SHALL return to 0 on that edge.
REQ-017 With PRESCALE=1 a step SHALL occur on every edge with en=1 (latency 1 cycle, en to count change).
REQ-018 en=0 SHALL freeze count and prescaler, and tc SHALL be 0 on the following cycle.
REQ-019 load=1 SHALL set count=load_val and clear the prescaler on that edge regardless of en; tc SHALL be 0 the following cycle; load_val > limit SHALL be accepted unchanged.
REQ-020 Up step, count < limit: count+1.
REQ-021 Up step, count >= limit: wrap mode -> 0; saturate mode -> limit (hold if equal); the step is a boundary event.
REQ-022 Down step, count > 0: count-1; if count > limit in saturate mode, the result is limit instead.
REQ-023 Down step, count = 0: wrap mode -> limit; saturate mode -> hold 0; the step is a boundary event.
REQ-024 A boundary event SHALL set tc=1 for exactly the cycle after that edge (coincident with the new count) and SHALL set ovf=1.
REQ-025 In saturate mode, repeated steps at the boundary SHALL each produce a tc pulse (tc high continuously while stepping at the boundary).
REQ-026 clr_ovf=1 SHALL clear ovf on that edge unless a boundary event occurs on the same edge, in which case ovf SHALL remain 1.
REQ-027 Changes of up, limit or sat_mode SHALL take effect at the next step with no extra latency; limit=0 SHALL make every step a boundary event.
REQ-028 All arithmetic SHALL be modulo 2^WIDTH unsigned; no internal carry-out SHALL be exposed except via tc/ovf.

Reset
REQ-029 rst=1 SHALL, on the next edge, set count=0, prescaler=0, tc=0, ovf=0, overriding load, en and clr_ovf.
REQ-030 rst asserted mid-count or mid-prescale SHALL discard partial prescaler progress; counting SHALL resume from 0 on the first enabled edge after rst falls.
REQ-031 Outputs SHALL be undefined only before the first rst edge; the bench SHALL apply rst for at least 2 cycles at startup.

Verification
REQ-032 WIDTH=4, PRESCALE=1, limit=15, up=1, en=1, wrap, rst released -> count 0,1,..,15,0; tc=1 only with count=0 after 15; ovf=1 thereafter.
REQ-033 limit=9, sat_mode=1, up=1 from 0 -> count reaches 9 and holds; tc high each enabled cycle at 9; clr_ovf pulse is ineffective while stepping at 9.
REQ-034 up=0 from count=0, limit=5, wrap -> count 5,4,3,2,1,0,5; tc on each arrival at 5.
REQ-035 PRESCALE=4, en=1 -> count increments every 4th edge; en dropped for 3 cycles mid-prescale -> step delayed exactly 3 cycles.
REQ-036 load=1, load_val=12, limit=9, up=1, wrap -> count=12 then 0 with tc; same in sat mode -> 9 with tc; load and rst on the same edge -> count=0.
REQ-037 rst pulsed while count=7 with en=1 -> count=0, ovf=0, tc=0 next cycle; count=1 one edge after rst deasserts.
